// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset PC, halt opcode, opcode fields and state type.
// The HALT state is only ever entered when HAP_FETCH_HALT_EN is defined.
package fetch_unit_pkg;

    localparam int          PKG_AW       = 8;
    localparam int          PKG_DW       = 16;
    localparam logic [7:0]  PKG_RESET_PC = 8'h00;
    localparam logic [15:0] HALT_OP      = 16'h0000;

    // 5-bit opcode field, shared with the branch unit
    localparam int         OPC_MSB = 15;
    localparam int         OPC_LSB = 11;
    localparam logic [4:0] OPC_HALT = 5'b00000;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_JMP  = 5'b10011;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO: power-of-two depth, push/pop/flush, head output forced to zero when empty.
module fetch_unit_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    // Storage needs no reset: the head is masked while empty
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, issue/kill control and run/halt state around a prefetch FIFO.
// Optional HALT-on-zero-word behaviour is enabled with HAP_FETCH_HALT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int            AW        = PKG_AW,
    parameter int            DW        = PKG_DW,
    parameter int            BUF_DEPTH = 2,
    parameter logic [AW-1:0] RESET_PC  = AW'(PKG_RESET_PC)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_imem_rd,
    output logic [AW-1:0] o_imem_addr,
    input  logic [DW-1:0] i_imem_data,
    output logic [DW-1:0] o_ir_data,
    output logic [AW-1:0] o_ir_npc,
    output logic          o_ir_valid,
    input  logic          i_ir_ready,
    input  logic          i_redirect,
    input  logic [AW-1:0] i_redirect_pc
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t  r_state;
    fetch_state_t  w_state_nxt;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_issued_pc;
    logic          r_inflight;

    logic          w_push;
    logic          w_pop;
    logic          w_issue;
    logic          w_halt_push;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_occ;
    logic [DW+AW-1:0] w_head;
    logic [AW-1:0] w_push_npc;

    // A redirect kills the response arriving in the same cycle
    assign w_push     = r_inflight && !i_redirect;
    assign w_pop      = o_ir_valid && i_ir_ready;
    assign w_push_npc = r_issued_pc + AW'(1);

`ifdef HAP_FETCH_HALT_EN
    assign w_halt_push = w_push && (i_imem_data == HALT_OP);
`else
    assign w_halt_push = 1'b0;
`endif

    // Counting the same-cycle pop lets the stage sustain one word per cycle
    assign w_occ   = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
    assign w_issue = !i_rst && (r_state == ST_RUN) && !i_redirect && !w_halt_push
                     && (w_occ < (CW+1)'(BUF_DEPTH));

    always_comb begin
        w_state_nxt = r_state;
        if (i_redirect) begin
            w_state_nxt = ST_RUN;
        end else if (w_halt_push) begin
            w_state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_issued_pc <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (i_redirect) begin
                r_pc <= i_redirect_pc;
            end else if (w_issue) begin
                r_pc        <= r_pc + AW'(1);
                r_issued_pc <= r_pc;
            end
        end
    end

    fetch_unit_fifo #(
        .W     (DW + AW),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (i_redirect),
        .i_data  ({i_imem_data, w_push_npc}),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    assign o_imem_rd   = w_issue;
    assign o_imem_addr = r_pc;
    assign o_ir_valid  = !w_empty;
    assign o_ir_data   = w_head[DW+AW-1:AW];
    assign o_ir_npc    = w_head[AW-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit; the model tracks the next expected fetch address.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_rd;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data = 16'h0;
    logic [15:0] ir_data;
    logic [7:0]  ir_npc;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h0;

    int total = 0;
    int bad   = 0;
    logic [7:0]  exp_addr = 8'h0;
    bit          pend_inv = 1'b0;
    int          n_deliv  = 0;
    logic [15:0] mem [256];

    fetch_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .o_imem_rd     (imem_rd),
        .o_imem_addr   (imem_addr),
        .i_imem_data   (imem_data),
        .o_ir_data     (ir_data),
        .o_ir_npc      (ir_npc),
        .o_ir_valid    (ir_valid),
        .i_ir_ready    (ir_ready),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data one cycle after the read strobe
    always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs after the edge, then score what the DUT presents
    task automatic cyc(input bit rdy, input bit redir, input logic [7:0] rpc);
        logic [7:0] nxt;
        @(posedge clk); #1;
        if (pend_inv) begin
            chk("inv_after_redirect", ir_valid, 0);
            pend_inv = 1'b0;
        end
        ir_ready = rdy; redirect = redir; redirect_pc = rpc;
        #1;
        if (!ir_valid) begin
            chk("empty_data_zero", ir_data, 0);
            chk("empty_npc_zero", ir_npc, 0);
        end else if (ir_ready) begin
            nxt = exp_addr + 8'd1;
            chk("deliv_data", ir_data, mem[exp_addr]);
            chk("deliv_npc", ir_npc, nxt);
            exp_addr = nxt;
            n_deliv++;
        end
        if (redir) begin
            exp_addr = rpc;
            pend_inv = 1'b1;
        end
    endtask

    task automatic do_reset(input bit rdy);
        @(posedge clk); #3;
        rst = 1'b1; redirect = 1'b0; ir_ready = rdy;
        #1;
        chk("rst_imem_rd", imem_rd, 0);
        chk("rst_valid", ir_valid, 0);
        chk("rst_data", ir_data, 0);
        chk("rst_npc", ir_npc, 0);
        chk("rst_addr", imem_addr, 0);
        @(posedge clk); #3;
        rst = 1'b0; exp_addr = 8'h00; pend_inv = 1'b0; n_deliv = 0;
        #1;
        chk("rel_imem_rd", imem_rd, 1);
        chk("rel_addr", imem_addr, 0);
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h9000 + 16'(a);

        // 1: reset, latency and streaming
        do_reset(1'b1);
        cyc(1, 0, 8'h0);
        chk("t1_addr1", imem_addr, 1);
        chk("t1_valid_lat", ir_valid, 0);
        cyc(1, 0, 8'h0);
        chk("t1_valid_rise", ir_valid, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 8'h0);
            chk("t1_stream_rd", imem_rd, 1);
            chk("t1_stream_addr", imem_addr, 32'(3 + i));
            chk("t1_stream_valid", ir_valid, 1);
        end

        // 2: backpressure from reset
        do_reset(1'b0);
        repeat (6) cyc(0, 0, 8'h0);
        chk("t2_valid", ir_valid, 1);
        chk("t2_rd_low", imem_rd, 0);
        chk("t2_pc", imem_addr, 2);
        chk("t2_none_yet", n_deliv, 0);
        repeat (3) cyc(1, 0, 8'h0);
        chk("t2_drained", n_deliv, 3);

        // 3: redirect during flow, then with a full FIFO
        repeat (2) cyc(1, 0, 8'h0);
        cyc(1, 1, 8'h40);
        chk("t3_no_rd", imem_rd, 0);
        cyc(1, 0, 8'h0);
        chk("t3_resume_rd", imem_rd, 1);
        chk("t3_resume_addr", imem_addr, 8'h40);
        repeat (3) cyc(1, 0, 8'h0);
        repeat (3) cyc(0, 0, 8'h0);
        cyc(0, 1, 8'h80);
        repeat (4) cyc(1, 0, 8'h0);

        // 4: PC wrap
        cyc(1, 1, 8'hFE);
        cyc(1, 0, 8'h0);
        chk("t4_addr_fe", imem_addr, 8'hFE);
        cyc(1, 0, 8'h0);
        chk("t4_addr_ff", imem_addr, 8'hFF);
        cyc(1, 0, 8'h0);
        chk("t4_addr_00", imem_addr, 8'h00);
        repeat (3) cyc(1, 0, 8'h0);

        // 5: asynchronous reset with a fetch inflight
        repeat (2) cyc(1, 0, 8'h0);
        do_reset(1'b1);
        repeat (4) cyc(1, 0, 8'h0);
        chk("t5_restart", n_deliv, 3);

        // 6: zero word at address 3
        mem[3] = 16'h0000;
        do_reset(1'b1);
        repeat (10) cyc(1, 0, 8'h0);
`ifdef HAP_FETCH_HALT_EN
        chk("t6_halt_count", n_deliv, 4);
        chk("t6_halt_rd", imem_rd, 0);
        chk("t6_halt_valid", ir_valid, 0);
`else
        chk("t6_nohalt_count", n_deliv, 9);
`endif
        cyc(1, 1, 8'h10);
        cyc(1, 0, 8'h0);
        chk("t6_resume_rd", imem_rd, 1);
        chk("t6_resume_addr", imem_addr, 8'h10);
        repeat (3) cyc(1, 0, 8'h0);
        mem[3] = 16'h9003;

        // Randomized ready / redirect traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), 8'($urandom));
        end
        repeat (4) cyc(1, 0, 8'h0);
        chk("rand_live_valid", ir_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
